agu_job_ctrl: RTL and testbench
===============================

AGU_JOB_CTRL -- requirements
Module: agu_job_ctrl

Interface
REQ-001 SHALL have parameter BCNT, default 16: bitwidth of the job length.
REQ-002 SHALL have parameter LAT, default 2, legal range 0..15: cycles from the last AGU step until the dependent pipeline output is valid.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: job request, sampled only in IDLE.
REQ-006 SHALL have port len  input  BCNT: number of AGU step cycles in the job, sampled together with start.
REQ-007 SHALL have port pause  input  1: stall request; present only when AGU_JOB_CTRL_PAUSE_EN is defined.
REQ-008 SHALL have port agu_clr  output  1: drives the clear input of the downstream address generator.
REQ-009 SHALL have port agu_en  output  1: drives the enable input of the downstream address generator.
REQ-010 SHALL have port busy  output  1: high in every state except IDLE.
REQ-011 SHALL have port done  output  1: one-cycle job-completion pulse.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, INIT, RUN, DRAIN and DONE; all outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.
REQ-013 IDLE with start=1 and len>0 SHALL latch len into the down-counter rcnt and go to INIT.
REQ-014 IDLE with start=1 and len=0 SHALL go directly to DONE; agu_clr and agu_en SHALL stay low.
REQ-015 INIT SHALL last exactly 1 cycle with agu_clr=1 and agu_en=0, then go to RUN.
REQ-016 RUN SHALL drive agu_en=1 and decrement rcnt on every cycle.
REQ-017 RUN SHALL last exactly the latched len cycles.
REQ-018 When rcnt reaches 1 in RUN, the FSM SHALL go to DRAIN if LAT>0, or to DONE if LAT=0.
REQ-019 DRAIN SHALL last exactly LAT cycles, counted by a separate counter, with agu_en=0.
REQ-020 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-021 Timing: for start accepted at edge t with len=L>0 and LAT=K:
- agu_clr is high in cycle t+1;
- agu_en is high in cycles t+2..t+1+L;
- done is high in cycle t+2+L+K.
REQ-022 start asserted in any state other than IDLE SHALL be ignored, with no queuing.
REQ-023 start asserted in the DONE cycle SHALL be ignored; a new job can be accepted from the first IDLE cycle onward.
REQ-024 len SHALL be treated as unsigned; len=2^BCNT-1 SHALL produce exactly that many agu_en cycles with no counter wrap.
REQ-025 Changes on len after acceptance SHALL NOT affect the running job.

Reset
REQ-026 clr=1 at a rising edge SHALL force state IDLE and clear rcnt and the drain counter.
REQ-027 From the next cycle after clr=1, agu_clr, agu_en, busy and done SHALL all be 0.
REQ-028 clr=1 mid-job SHALL abort the job with no done pulse.
REQ-029 clr SHALL have priority over start and pause in the same cycle.

Configuration
REQ-030 With AGU_JOB_CTRL_PAUSE_EN defined, pause=1 in RUN SHALL force agu_en=0 and hold rcnt and the state for that cycle.
REQ-031 With AGU_JOB_CTRL_PAUSE_EN defined, pause SHALL have no effect in IDLE, INIT, DRAIN and DONE.
REQ-032 With AGU_JOB_CTRL_PAUSE_EN defined, agu_en SHALL depend combinationally on pause; this is the only permitted exception to REQ-012.
REQ-033 With AGU_JOB_CTRL_PAUSE_EN undefined, the pause port SHALL not exist and RUN SHALL never stall.

Verification
REQ-034 Basic job: LAT=2, start at edge 0 with len=3 -> agu_clr in cycle 1, agu_en in cycles 2-4, done in cycle 7, busy in cycles 1-7.
REQ-035 Zero-length job: start with len=0 -> done the next cycle; agu_clr and agu_en never asserted; busy high for that single cycle.
REQ-036 Ignored start: start re-pulsed with len=9 during RUN and during DONE of a len=4 job -> exactly 4 agu_en cycles and one done pulse; the following IDLE start is accepted.
REQ-037 Reset mid-job: clr=1 in the 2nd RUN cycle of a len=10 job -> all outputs 0 from the next cycle, no done pulse; a new len=2 job then runs normally.
REQ-038 Pause (macro defined): len=4, pause high for 3 cycles starting at the 2nd RUN cycle -> exactly 4 agu_en cycles in total, and done 3 cycles later than in the unpaused job.
REQ-039 Boundary: BCNT=4, LAT=0, len=15 -> 15 agu_en cycles, done in the cycle immediately after the last agu_en cycle.

Source files
------------

// File: rtl/agu_job_ctrl_if.sv
// Handshake bundle between a job requester and agu_job_ctrl.
// The pause signal exists only when AGU_JOB_CTRL_PAUSE_EN is defined.
interface agu_job_ctrl_if #(
    parameter int BCNT = 16
);
    logic            start;
    logic [BCNT-1:0] len;
`ifdef AGU_JOB_CTRL_PAUSE_EN
    logic            pause;
`endif
    logic            agu_clr;
    logic            agu_en;
    logic            busy;
    logic            done;

    modport master (
        output start, len,
`ifdef AGU_JOB_CTRL_PAUSE_EN
        pause,
`endif
        input  agu_clr, agu_en, busy, done
    );

    modport slave (
        input  start, len,
`ifdef AGU_JOB_CTRL_PAUSE_EN
        pause,
`endif
        output agu_clr, agu_en, busy, done
    );
endinterface

// File: rtl/agu_job_ctrl.sv
// Job sequencer for a downstream address generator: clear, step len cycles, drain LAT cycles, pulse done.
// Optional RUN stall input enabled by defining AGU_JOB_CTRL_PAUSE_EN.
module agu_job_ctrl #(
    parameter int BCNT = 16,
    parameter int LAT  = 2
) (
    input  logic          clk,
    input  logic          clr,
    agu_job_ctrl_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for start
    // INIT   | one-cycle clear of the address generator
    // RUN    | address generator stepping, rcnt counts remaining steps
    // DRAIN  | waiting for the dependent pipeline, dcnt counts remaining cycles
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t          state_q, state_d;
    logic [BCNT-1:0] rcnt_q, rcnt_d;
    logic [3:0]      dcnt_q, dcnt_d;
    logic            stall;

`ifdef AGU_JOB_CTRL_PAUSE_EN
    assign stall = bus.pause;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        rcnt_d  = bus.len;
                        state_d = S_INIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                // Terminal count at 1 so a full-scale len never needs a wrap.
                if (!stall) begin
                    rcnt_d = rcnt_q - BCNT'(1);
                    if (rcnt_q == BCNT'(1)) begin
                        if (LAT_C != 4'd0) begin
                            dcnt_d  = LAT_C;
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q - 4'd1;
                if (dcnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.agu_clr = (state_q == S_INIT);
    assign bus.agu_en  = (state_q == S_RUN) && !stall;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
endmodule

// File: tb/tb_agu_job_ctrl.sv
// Directed bench for agu_job_ctrl: default instance (BCNT=16, LAT=2) and a boundary
// instance (BCNT=4, LAT=0). Output traces are captured as per-cycle bit vectors.
module tb_agu_job_ctrl;
    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;

    agu_job_ctrl_if #(.BCNT(16)) a ();
    agu_job_ctrl_if #(.BCNT(4))  b ();

    agu_job_ctrl #(.BCNT(16), .LAT(2)) u_dut_a (.clk(clk), .clr(clr), .bus(a));
    agu_job_ctrl #(.BCNT(4),  .LAT(0)) u_dut_b (.clk(clk), .clr(clr), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Bit e of a pattern is the input value sampled at edge e; bit c of a trace is
    // the output value during cycle c (between edge c-1 and edge c).
    task automatic run_pat(input bit sel, input logic [31:0] st_p, input logic [31:0] cl_p,
                           input logic [31:0] pa_p, input logic [15:0] l0, input logic [15:0] l1,
                           input int n, output logic [31:0] o_clr, output logic [31:0] o_en,
                           output logic [31:0] o_busy, output logic [31:0] o_done);
        o_clr  = '0;
        o_en   = '0;
        o_busy = '0;
        o_done = '0;
        @(negedge clk);
        for (int e = 0; e < n; e++) begin
            clr = cl_p[e];
            if (sel) begin
                b.start = st_p[e];
                b.len   = (e == 0) ? l0[3:0] : l1[3:0];
            end else begin
                a.start = st_p[e];
                a.len   = (e == 0) ? l0 : l1;
            end
`ifdef AGU_JOB_CTRL_PAUSE_EN
            a.pause = pa_p[e];
            b.pause = pa_p[e];
`else
            if (pa_p != 32'd0) $display("note: pause pattern ignored in this build");
`endif
            @(negedge clk);
            o_clr[e+1]  = sel ? b.agu_clr : a.agu_clr;
            o_en[e+1]   = sel ? b.agu_en  : a.agu_en;
            o_busy[e+1] = sel ? b.busy    : a.busy;
            o_done[e+1] = sel ? b.done    : a.done;
        end
        clr     = 1'b0;
        a.start = 1'b0;
        b.start = 1'b0;
`ifdef AGU_JOB_CTRL_PAUSE_EN
        a.pause = 1'b0;
        b.pause = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [31:0] vc, ve, vb, vd;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (a.agu_clr !== 1'b0) begin n_err++; $display("FAIL reset_a_agu_clr got %b want 0", a.agu_clr); end
        n_cmp++; if (a.agu_en  !== 1'b0) begin n_err++; $display("FAIL reset_a_agu_en got %b want 0", a.agu_en); end
        n_cmp++; if (a.busy    !== 1'b0) begin n_err++; $display("FAIL reset_a_busy got %b want 0", a.busy); end
        n_cmp++; if (a.done    !== 1'b0) begin n_err++; $display("FAIL reset_a_done got %b want 0", a.done); end
        n_cmp++; if (b.agu_clr !== 1'b0) begin n_err++; $display("FAIL reset_b_agu_clr got %b want 0", b.agu_clr); end
        n_cmp++; if (b.agu_en  !== 1'b0) begin n_err++; $display("FAIL reset_b_agu_en got %b want 0", b.agu_en); end
        n_cmp++; if (b.busy    !== 1'b0) begin n_err++; $display("FAIL reset_b_busy got %b want 0", b.busy); end
        n_cmp++; if (b.done    !== 1'b0) begin n_err++; $display("FAIL reset_b_done got %b want 0", b.done); end
        clr = 1'b0;
        // clr and start together at the same edge: clr wins, nothing starts
        run_pat(1'b0, 32'h1, 32'h1, 32'h0, 16'd5, 16'd5, 4, vc, ve, vb, vd);
        n_cmp++; if (vc !== 32'h0) begin n_err++; $display("FAIL prio_agu_clr got %h want %h", vc, 32'h0); end
        n_cmp++; if (ve !== 32'h0) begin n_err++; $display("FAIL prio_agu_en got %h want %h", ve, 32'h0); end
        n_cmp++; if (vb !== 32'h0) begin n_err++; $display("FAIL prio_busy got %h want %h", vb, 32'h0); end
        n_cmp++; if (vd !== 32'h0) begin n_err++; $display("FAIL prio_done got %h want %h", vd, 32'h0); end
    endtask

    task automatic test_basic();
        logic [31:0] vc, ve, vb, vd;
        run_pat(1'b0, 32'h1, 32'h0, 32'h0, 16'd3, 16'd3, 10, vc, ve, vb, vd);
        n_cmp++; if (vc !== 32'h0000_0002) begin n_err++; $display("FAIL basic_agu_clr got %h want %h", vc, 32'h2); end
        n_cmp++; if (ve !== 32'h0000_001C) begin n_err++; $display("FAIL basic_agu_en got %h want %h", ve, 32'h1C); end
        n_cmp++; if (vb !== 32'h0000_00FE) begin n_err++; $display("FAIL basic_busy got %h want %h", vb, 32'hFE); end
        n_cmp++; if (vd !== 32'h0000_0080) begin n_err++; $display("FAIL basic_done got %h want %h", vd, 32'h80); end
    endtask

    task automatic test_zero_len();
        logic [31:0] vc, ve, vb, vd;
        run_pat(1'b0, 32'h1, 32'h0, 32'h0, 16'd0, 16'd0, 5, vc, ve, vb, vd);
        n_cmp++; if (vc !== 32'h0) begin n_err++; $display("FAIL zero_agu_clr got %h want %h", vc, 32'h0); end
        n_cmp++; if (ve !== 32'h0) begin n_err++; $display("FAIL zero_agu_en got %h want %h", ve, 32'h0); end
        n_cmp++; if (vb !== 32'h2) begin n_err++; $display("FAIL zero_busy got %h want %h", vb, 32'h2); end
        n_cmp++; if (vd !== 32'h2) begin n_err++; $display("FAIL zero_done got %h want %h", vd, 32'h2); end
    endtask

    task automatic test_ignored_start();
        logic [31:0] vc, ve, vb, vd;
        // len=4 job; start with len=9 at edge 3 (RUN) and 8 (DONE) is ignored, edge 9 (IDLE) accepted
        run_pat(1'b0, 32'h0000_0309, 32'h0, 32'h0, 16'd4, 16'd9, 24, vc, ve, vb, vd);
        n_cmp++; if (vc !== 32'h0000_0402) begin n_err++; $display("FAIL ign_agu_clr got %h want %h", vc, 32'h402); end
        n_cmp++; if (ve !== 32'h000F_F83C) begin n_err++; $display("FAIL ign_agu_en got %h want %h", ve, 32'hFF83C); end
        n_cmp++; if (vb !== 32'h007F_FDFE) begin n_err++; $display("FAIL ign_busy got %h want %h", vb, 32'h7FFDFE); end
        n_cmp++; if (vd !== 32'h0040_0100) begin n_err++; $display("FAIL ign_done got %h want %h", vd, 32'h400100); end
    endtask

    task automatic test_clr_mid_job();
        logic [31:0] vc, ve, vb, vd;
        // len=10 job aborted in its 2nd RUN cycle, then len=2 job from edge 5
        run_pat(1'b0, 32'h21, 32'h8, 32'h0, 16'd10, 16'd2, 14, vc, ve, vb, vd);
        n_cmp++; if (vc !== 32'h0000_0042) begin n_err++; $display("FAIL clr_agu_clr got %h want %h", vc, 32'h42); end
        n_cmp++; if (ve !== 32'h0000_018C) begin n_err++; $display("FAIL clr_agu_en got %h want %h", ve, 32'h18C); end
        n_cmp++; if (vb !== 32'h0000_0FCE) begin n_err++; $display("FAIL clr_busy got %h want %h", vb, 32'hFCE); end
        n_cmp++; if (vd !== 32'h0000_0800) begin n_err++; $display("FAIL clr_done got %h want %h", vd, 32'h800); end
    endtask

    task automatic test_boundary();
        logic [31:0] vc, ve, vb, vd;
        run_pat(1'b1, 32'h1, 32'h0, 32'h0, 16'd15, 16'd15, 20, vc, ve, vb, vd);
        n_cmp++; if (vc !== 32'h0000_0002) begin n_err++; $display("FAIL bnd15_agu_clr got %h want %h", vc, 32'h2); end
        n_cmp++; if (ve !== 32'h0001_FFFC) begin n_err++; $display("FAIL bnd15_agu_en got %h want %h", ve, 32'h1FFFC); end
        n_cmp++; if (vb !== 32'h0003_FFFE) begin n_err++; $display("FAIL bnd15_busy got %h want %h", vb, 32'h3FFFE); end
        n_cmp++; if (vd !== 32'h0002_0000) begin n_err++; $display("FAIL bnd15_done got %h want %h", vd, 32'h20000); end
        run_pat(1'b1, 32'h1, 32'h0, 32'h0, 16'd1, 16'd1, 6, vc, ve, vb, vd);
        n_cmp++; if (vc !== 32'h2) begin n_err++; $display("FAIL bnd1_agu_clr got %h want %h", vc, 32'h2); end
        n_cmp++; if (ve !== 32'h4) begin n_err++; $display("FAIL bnd1_agu_en got %h want %h", ve, 32'h4); end
        n_cmp++; if (vb !== 32'hE) begin n_err++; $display("FAIL bnd1_busy got %h want %h", vb, 32'hE); end
        n_cmp++; if (vd !== 32'h8) begin n_err++; $display("FAIL bnd1_done got %h want %h", vd, 32'h8); end
    endtask

`ifdef AGU_JOB_CTRL_PAUSE_EN
    task automatic test_pause();
        logic [31:0] vc, ve, vb, vd;
        // pause at edges 3-5 stalls RUN; pause at 1 (INIT), 9 (DRAIN) and 12 (IDLE) has no effect
        run_pat(1'b0, 32'h1, 32'h0, 32'h0000_123A, 16'd4, 16'd4, 14, vc, ve, vb, vd);
        n_cmp++; if (vc !== 32'h0000_0002) begin n_err++; $display("FAIL pause_agu_clr got %h want %h", vc, 32'h2); end
        n_cmp++; if (ve !== 32'h0000_01C4) begin n_err++; $display("FAIL pause_agu_en got %h want %h", ve, 32'h1C4); end
        n_cmp++; if (vb !== 32'h0000_0FFE) begin n_err++; $display("FAIL pause_busy got %h want %h", vb, 32'hFFE); end
        n_cmp++; if (vd !== 32'h0000_0800) begin n_err++; $display("FAIL pause_done got %h want %h", vd, 32'h800); end
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        clr     = 1'b1;
        a.start = 1'b0;
        a.len   = '0;
        b.start = 1'b0;
        b.len   = '0;
`ifdef AGU_JOB_CTRL_PAUSE_EN
        a.pause = 1'b0;
        b.pause = 1'b0;
`endif
        test_reset();
        test_basic();
        test_zero_len();
        test_ignored_start();
        test_clr_mid_job();
        test_boundary();
`ifdef AGU_JOB_CTRL_PAUSE_EN
        test_pause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
